// File: rtl/single_port_blockram_controller_pkg.sv
// Shared definitions for the single-port block RAM controller.
//   - BYTE_LEN_IN_BITS : width of one byte lane covered by a write-mask bit
//   - state_e          : controller FSM encodings (zero-fill sweep, then active)
//   - credit_cnt_width : width needed to count 0..depth outstanding responses
package single_port_blockram_controller_pkg;

    localparam int unsigned BYTE_LEN_IN_BITS = 8;

    typedef enum logic [0:0] {
        STATE_INIT   = 1'b0,
        STATE_ACTIVE = 1'b1
    } state_e;

    function automatic int unsigned credit_cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/blockram_response_fifo.sv
// Synchronous FIFO buffering read responses from the block RAM.
// Ports:
//   i_clk, i_reset     : clock, asynchronous active-high reset (empties the FIFO)
//   i_push, i_push_data: write one entry (ignored when full)
//   i_pop              : remove the head entry (ignored when empty)
//   o_pop_data         : head entry, forced to 0 while empty
//   o_full, o_empty    : occupancy flags
//   o_count            : number of stored entries
module blockram_response_fifo
    import single_port_blockram_controller_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = credit_cnt_width(DEPTH),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    // Stale storage must not leak out after reset, so the head reads as 0 when empty.
    assign o_pop_data = o_empty ? '0 : r_mem[r_rptr];
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The controller's credit scheme makes overflow impossible.
    a_no_overflow : assert property (@(posedge i_clk) disable iff (i_reset) !(i_push && o_full))
        else $error("blockram_response_fifo: push while full");

endmodule

// File: rtl/single_port_blockram_controller.sv
// Initiator-side front end for single_port_blockram.
// After reset it zero-fills every set, then accepts byte-masked requests (mask of all
// zeros = read) and returns read data through a buffered valid/ready response channel.
// Ports:
//   clk_in, reset_in              : clock, asynchronous active-high reset
//   request_*                     : valid/ready request channel (mask, set, write data)
//   response_*                    : valid/ready read-response channel
//   init_done_out                 : zero-fill sweep complete
//   ram_*                         : direct connection to the RAM ports
module single_port_blockram_controller
    import single_port_blockram_controller_pkg::*;
#(
    parameter int unsigned SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int unsigned NUM_SET                   = 64,
    parameter int unsigned SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int unsigned WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS,
    parameter int unsigned READ_LATENCY              = 1,
    parameter int unsigned RESPONSE_FIFO_DEPTH       = 4
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    input  logic                                 request_valid_in,
    output logic                                 request_ready_out,
    input  logic [WRITE_MASK_LEN-1:0]            request_write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     request_set_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_write_entry_in,
    output logic                                 response_valid_out,
    input  logic                                 response_ready_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] response_entry_out,
    output logic                                 init_done_out,
    output logic                                 ram_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]            ram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]     ram_set_addr_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_write_entry_out,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_read_entry_in
);

    localparam int unsigned CREDIT_W = credit_cnt_width(RESPONSE_FIFO_DEPTH);
    localparam int unsigned SUM_W    = CREDIT_W + 1;

    state_e                                 r_state;
    state_e                                 w_state_next;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]       r_sweep_cnt;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]       w_sweep_cnt_next;
    logic                                   r_init_done;
    logic                                   w_init_done_next;

    // RAM port registers: the RAM is driven from flops so every port is 0 in reset.
    logic                                   r_ram_access_en;
    logic [WRITE_MASK_LEN-1:0]              r_ram_write_en;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]       r_ram_set_addr;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   r_ram_write_entry;
    logic                                   w_ram_access_en_next;
    logic [WRITE_MASK_LEN-1:0]              w_ram_write_en_next;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]       w_ram_set_addr_next;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   w_ram_write_entry_next;

    // Bit i set: a read accessed the RAM i+1 cycles ago.
    logic [READ_LATENCY-1:0]                r_rd_pipe;
    logic                                   w_access_is_read;
    logic [SUM_W-1:0]                       w_inflight;
    logic [SUM_W-1:0]                       w_credit_used;
    logic                                   w_ready;

    logic [CREDIT_W-1:0]                    w_fifo_count;
    logic                                   w_fifo_full;
    logic                                   w_fifo_empty;
    logic                                   w_fifo_push;
    logic                                   w_fifo_pop;

    assign w_access_is_read = r_ram_access_en && (r_ram_write_en == '0);

    // Reads occupying a future FIFO slot: the one in its RAM access cycle plus those
    // waiting out the read latency.
    always_comb begin
        w_inflight = SUM_W'(w_access_is_read);
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            w_inflight = w_inflight + SUM_W'(r_rd_pipe[i]);
        end
    end

    assign w_credit_used = SUM_W'(w_fifo_count) + w_inflight;

    always_comb begin
        w_state_next           = r_state;
        w_sweep_cnt_next       = r_sweep_cnt;
        w_init_done_next       = r_init_done;
        w_ram_access_en_next   = 1'b0;
        w_ram_write_en_next    = '0;
        w_ram_set_addr_next    = r_ram_set_addr;
        w_ram_write_entry_next = r_ram_write_entry;
        w_ready                = 1'b0;
        case (r_state)
            STATE_INIT: begin
                w_ram_access_en_next   = 1'b1;
                w_ram_write_en_next    = '1;
                w_ram_write_entry_next = '0;
                w_ram_set_addr_next    = r_sweep_cnt;
                // Counter parks at the last set instead of wrapping.
                if (r_sweep_cnt == SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1)) begin
                    w_state_next     = STATE_ACTIVE;
                    w_init_done_next = 1'b1;
                end else begin
                    w_sweep_cnt_next = r_sweep_cnt + 1'b1;
                end
            end
            STATE_ACTIVE: begin
                // Credit check covers writes too, keeping request order simple.
                w_ready = (w_credit_used < SUM_W'(RESPONSE_FIFO_DEPTH));
                if (request_valid_in && w_ready) begin
                    w_ram_access_en_next   = 1'b1;
                    w_ram_write_en_next    = request_write_en_in;
                    w_ram_set_addr_next    = request_set_addr_in;
                    w_ram_write_entry_next = request_write_entry_in;
                end
            end
            default: begin
                w_state_next = STATE_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state           <= STATE_INIT;
            r_sweep_cnt       <= '0;
            r_init_done       <= 1'b0;
            r_ram_access_en   <= 1'b0;
            r_ram_write_en    <= '0;
            r_ram_set_addr    <= '0;
            r_ram_write_entry <= '0;
            r_rd_pipe         <= '0;
        end else begin
            r_state           <= w_state_next;
            r_sweep_cnt       <= w_sweep_cnt_next;
            r_init_done       <= w_init_done_next;
            r_ram_access_en   <= w_ram_access_en_next;
            r_ram_write_en    <= w_ram_write_en_next;
            r_ram_set_addr    <= w_ram_set_addr_next;
            r_ram_write_entry <= w_ram_write_entry_next;
            r_rd_pipe[0]      <= w_access_is_read;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
        end
    end

    assign w_fifo_push = r_rd_pipe[READ_LATENCY-1];
    assign w_fifo_pop  = response_valid_out && response_ready_in;

    blockram_response_fifo #(
        .WIDTH (SINGLE_ENTRY_SIZE_IN_BITS),
        .DEPTH (RESPONSE_FIFO_DEPTH)
    ) u_response_fifo (
        .i_clk       (clk_in),
        .i_reset     (reset_in),
        .i_push      (w_fifo_push),
        .i_push_data (ram_read_entry_in),
        .i_pop       (w_fifo_pop),
        .o_pop_data  (response_entry_out),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign request_ready_out   = w_ready;
    assign response_valid_out  = !w_fifo_empty;
    assign init_done_out       = r_init_done;
    assign ram_access_en_out   = r_ram_access_en;
    assign ram_write_en_out    = r_ram_write_en;
    assign ram_set_addr_out    = r_ram_set_addr;
    assign ram_write_entry_out = r_ram_write_entry;

    logic w_unused;
    assign w_unused = w_fifo_full;

endmodule

// File: tb/tb_single_port_blockram_controller.sv
// Directed bench for single_port_blockram_controller with a behavioural 1-cycle RAM.
module tb_single_port_blockram_controller;

    logic        clk_in;
    logic        reset_in;
    logic        request_valid_in;
    logic        request_ready_out;
    logic [7:0]  request_write_en_in;
    logic [5:0]  request_set_addr_in;
    logic [63:0] request_write_entry_in;
    logic        response_valid_out;
    logic        response_ready_in;
    logic [63:0] response_entry_out;
    logic        init_done_out;
    logic        ram_access_en_out;
    logic [7:0]  ram_write_en_out;
    logic [5:0]  ram_set_addr_out;
    logic [63:0] ram_write_entry_out;
    logic [63:0] ram_read_entry_in;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [63:0] mem [64];

    single_port_blockram_controller dut (
        .clk_in                 (clk_in),
        .reset_in               (reset_in),
        .request_valid_in       (request_valid_in),
        .request_ready_out      (request_ready_out),
        .request_write_en_in    (request_write_en_in),
        .request_set_addr_in    (request_set_addr_in),
        .request_write_entry_in (request_write_entry_in),
        .response_valid_out     (response_valid_out),
        .response_ready_in      (response_ready_in),
        .response_entry_out     (response_entry_out),
        .init_done_out          (init_done_out),
        .ram_access_en_out      (ram_access_en_out),
        .ram_write_en_out       (ram_write_en_out),
        .ram_set_addr_out       (ram_set_addr_out),
        .ram_write_entry_out    (ram_write_entry_out),
        .ram_read_entry_in      (ram_read_entry_in)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // RAM model: byte-masked write, or registered read when the mask is zero.
    always @(posedge clk_in) begin
        if (ram_access_en_out) begin
            if (ram_write_en_out == 8'h00) begin
                ram_read_entry_in <= mem[ram_set_addr_out];
            end else begin
                for (int b = 0; b < 8; b++) begin
                    if (ram_write_en_out[b]) begin
                        mem[ram_set_addr_out][b*8 +: 8] <= ram_write_entry_out[b*8 +: 8];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [7:0] mask, input logic [5:0] addr,
                         input logic [63:0] data, output int acc_cyc);
        request_valid_in       = 1'b1;
        request_write_en_in    = mask;
        request_set_addr_in    = addr;
        request_write_entry_in = data;
        acc_cyc = -1;
        for (int n = 0; n < 20; n++) begin
            if (request_ready_out) begin
                tick();
                acc_cyc = cyc;
                break;
            end
            tick();
        end
        request_valid_in = 1'b0;
        if (acc_cyc < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: addr %0d never accepted, got ready=0 expected ready=1",
                     addr);
        end
    endtask

    task automatic read_check(input logic [5:0] addr, input logic [63:0] exp,
                              input string name);
        int acc;
        issue(8'h00, addr, 64'h5A5A_5A5A_5A5A_5A5A, acc);
        n_checks++;
        if (response_valid_out !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_early: got valid=%b expected valid=0", name, response_valid_out);
        end
        tick();
        n_checks++;
        if (response_valid_out !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_early2: got valid=%b expected valid=0", name, response_valid_out);
        end
        tick();
        n_checks++;
        if ({response_valid_out, response_entry_out} !== {1'b1, exp} || (cyc - acc) != 2) begin
            n_errors++;
            $display("FAIL %s: got valid=%b data=%h at +%0d expected valid=1 data=%h at +2",
                     name, response_valid_out, response_entry_out, cyc - acc, exp);
        end
        tick();
    endtask

    task automatic check_sweep(input string name);
        int bad;
        int first_bad;
        bad = 0;
        first_bad = -1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (ram_access_en_out !== 1'b1 || ram_write_en_out !== 8'hFF ||
                ram_set_addr_out !== 6'(k - 1) || ram_write_entry_out !== 64'h0 ||
                init_done_out !== (k == 64) || request_ready_out !== (k == 64) ||
                response_valid_out !== 1'b0) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL %s: got %0d bad sweep cycles (first %0d) expected 0",
                     name, bad, first_bad);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if ({request_ready_out, response_valid_out, response_entry_out, init_done_out,
             ram_access_en_out, ram_write_en_out, ram_set_addr_out,
             ram_write_entry_out} !== '0) begin
            n_errors++;
            $display("FAIL %s: got rdy=%b vld=%b data=%h done=%b acc=%b we=%h addr=%h wd=%h expected all 0",
                     name, request_ready_out, response_valid_out, response_entry_out,
                     init_done_out, ram_access_en_out, ram_write_en_out, ram_set_addr_out,
                     ram_write_entry_out);
        end
    endtask

    task automatic test_reset();
        int nz;
        reset_in = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset_outputs");
        reset_in = 1'b0;
        check_sweep("init_sweep");
        tick();
        nz = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 64'h0) nz++;
        n_checks++;
        if (nz != 0) begin
            n_errors++;
            $display("FAIL zero_fill: got %0d nonzero sets expected 0", nz);
        end
        read_check(6'd5, 64'h0, "read_zero_addr5");
    endtask

    task automatic test_full_write();
        int acc;
        int seen;
        issue(8'hFF, 6'd63, 64'hFFFF_FFFF_0000_0000, acc);
        seen = 0;
        repeat (3) begin
            if (response_valid_out !== 1'b0) seen++;
            tick();
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL write_no_response: got %0d valid cycles expected 0", seen);
        end
        read_check(6'd63, 64'hFFFF_FFFF_0000_0000, "read_addr63");
    endtask

    task automatic test_byte_mask();
        int acc;
        issue(8'hFF, 6'd62, 64'h0, acc);
        issue(8'hCC, 6'd62, 64'hFFFF_FFFF_FFFF_FFFF, acc);
        read_check(6'd62, 64'hFFFF_0000_FFFF_0000, "byte_mask_cc");
    endtask

    task automatic test_back_to_back();
        int acc;
        issue(8'hFF, 6'd7, 64'h1234, acc);
        read_check(6'd7, 64'h1234, "raw_addr7");
        // read_check issues mask 0 with nonzero data: contents must survive it.
        read_check(6'd7, 64'h1234, "mask0_no_modify");
    endtask

    task automatic test_backpressure();
        int acc;
        int accepted;
        logic [63:0] got [$];
        logic [63:0] g;
        for (int i = 0; i < 6; i++) issue(8'hFF, 6'(10 + i), 64'hA0 + 64'(i), acc);
        repeat (3) tick();
        response_ready_in      = 1'b0;
        accepted               = 0;
        request_valid_in       = 1'b1;
        request_write_en_in    = 8'h00;
        request_set_addr_in    = 6'd10;
        request_write_entry_in = 64'h0;
        for (int n = 0; n < 12; n++) begin
            if (request_ready_out && request_valid_in) begin
                tick();
                accepted++;
                request_set_addr_in = 6'(10 + accepted);
                if (accepted == 6) request_valid_in = 1'b0;
            end else begin
                tick();
            end
        end
        n_checks++;
        if (accepted != 4) begin
            n_errors++;
            $display("FAIL bp_accepted: got %0d expected 4", accepted);
        end
        n_checks++;
        if (request_ready_out !== 1'b0 || response_valid_out !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_stall: got ready=%b valid=%b expected ready=0 valid=1",
                     request_ready_out, response_valid_out);
        end
        request_valid_in  = 1'b0;
        response_ready_in = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (response_valid_out) got.push_back(response_entry_out);
            tick();
        end
        n_checks++;
        if (got.size() != 4) begin
            n_errors++;
            $display("FAIL bp_count: got %0d responses expected 4", got.size());
        end
        for (int i = 0; i < 4; i++) begin
            g = (i < got.size()) ? got[i] : 64'hx;
            n_checks++;
            if (g !== 64'hA0 + 64'(i)) begin
                n_errors++;
                $display("FAIL bp_order[%0d]: got %h expected %h", i, g, 64'hA0 + 64'(i));
            end
        end
    endtask

    task automatic test_reset_midstream();
        response_ready_in      = 1'b1;
        request_valid_in       = 1'b1;
        request_write_en_in    = 8'h00;
        request_set_addr_in    = 6'd20;
        tick();
        request_set_addr_in    = 6'd21;
        tick();
        request_valid_in       = 1'b0;
        #3;
        reset_in = 1'b1;
        #1;
        check_outputs_zero("midreset_immediate");
        repeat (2) tick();
        check_outputs_zero("midreset_held");
        reset_in = 1'b0;
        check_sweep("sweep_after_reset");
        repeat (4) tick();
        n_checks++;
        if (response_valid_out !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_stale: got valid=%b expected valid=0", response_valid_out);
        end
        read_check(6'd63, 64'h0, "refilled_addr63");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i + 1);
        ram_read_entry_in      = 64'h0;
        reset_in               = 1'b1;
        request_valid_in       = 1'b0;
        request_write_en_in    = 8'h00;
        request_set_addr_in    = 6'd0;
        request_write_entry_in = 64'h0;
        response_ready_in      = 1'b1;
        #2;
        test_reset();
        test_full_write();
        test_byte_mask();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
